// File: rtl/omem_wb_write_buffer.sv
// omem_wb_write_buffer: FIFO of 96-bit result rows, each drained as three
// 32-bit Wishbone classic write cycles (X, Y, Z) at consecutive word addresses.
module omem_wb_write_buffer #(
    parameter int WB_WIDTH  = 32,
    parameter int ROW_WIDTH = 96,
    parameter int DEPTH     = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 iWriteEnable,
    input  logic [WB_WIDTH-1:0]  iAddress,
    input  logic [ROW_WIDTH-1:0] iData,
    output logic                 oFull,
    output logic                 oEmpty,
    output logic                 oOverflow,
    output logic [WB_WIDTH-1:0]  ADR_O,
    output logic [WB_WIDTH-1:0]  DAT_O,
    output logic                 WE_O,
    output logic                 STB_O,
    output logic                 CYC_O,
    input  logic                 ACK_I
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ROW_WIDTH + WB_WIDTH;

    typedef enum logic {IDLE, XFER} state_t;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
    logic [CW-1:0]       count_q, count_d;
    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                stb_q, stb_d, ovf_q, ovf_d, empty_q, empty_d;
    logic [WB_WIDTH-1:0] adr_q, adr_d, dat_q, dat_d;
    logic [EW-1:0]       head;
    logic                full, push, pop;

    assign full    = count_q == CW'(DEPTH);
    assign push    = iWriteEnable && !full;
    assign head    = mem_q[rd_ptr_q];
    assign nxt_ptr = rd_ptr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (count_q != '0) begin
                state_d = XFER;
                beat_d  = 2'd0;
                stb_d   = 1'b1;
                adr_d   = head[EW-1 -: WB_WIDTH];
                dat_d   = head[ROW_WIDTH-1 -: WB_WIDTH];
            end
        end else if (ACK_I) begin
            if (beat_q != 2'd2) begin
                beat_d = beat_q + 2'd1;
                adr_d  = head[EW-1 -: WB_WIDTH] + WB_WIDTH'(beat_q) + WB_WIDTH'(1);
                dat_d  = (beat_q == 2'd0) ? head[2*WB_WIDTH-1 -: WB_WIDTH] : head[WB_WIDTH-1:0];
            end else begin
                pop = 1'b1;
                // Another row already queued: chain straight into it with CYC_O held.
                if (count_q > CW'(1)) begin
                    beat_d = 2'd0;
                    adr_d  = mem_q[nxt_ptr][EW-1 -: WB_WIDTH];
                    dat_d  = mem_q[nxt_ptr][ROW_WIDTH-1 -: WB_WIDTH];
                end else begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                end
            end
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (iWriteEnable & full);
        empty_d  = (count_d == '0) && (state_d == IDLE);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            stb_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            stb_q    <= stb_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_ptr_q] <= {iAddress, iData};
    end

    assign oFull     = full;
    assign oEmpty    = empty_q;
    assign oOverflow = ovf_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign WE_O      = stb_q;
    assign STB_O     = stb_q;
    assign CYC_O     = stb_q;
endmodule

// File: tb/tb_omem_wb_write_buffer.sv
// tb_omem_wb_write_buffer: directed stimulus; expected Wishbone beats are queued
// at push time and checked by a negedge monitor whenever STB_O is high.
module tb_omem_wb_write_buffer;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        iWriteEnable = 1'b0;
    logic [31:0] iAddress = '0;
    logic [95:0] iData = '0;
    logic        oFull, oEmpty, oOverflow;
    logic [31:0] ADR_O, DAT_O;
    logic        WE_O, STB_O, CYC_O;
    logic        ACK_I = 1'b0;

    omem_wb_write_buffer dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .iWriteEnable(iWriteEnable),
        .iAddress(iAddress), .iData(iData), .oFull(oFull), .oEmpty(oEmpty),
        .oOverflow(oOverflow), .ADR_O(ADR_O), .DAT_O(DAT_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    logic [63:0] exp_q [$];
    int checks = 0, failures = 0;
    int mon_checks = 0, mon_failures = 0;
    int beats = 0, stb_cycles = 0;

    task automatic mchk(string name, logic [31:0] act, logic [31:0] exp);
        mon_checks++;
        if (act !== exp) begin
            mon_failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK_I) begin
        if (!RST_I && STB_O) begin
            stb_cycles++;
            if (exp_q.size() == 0) begin
                mon_checks++;
                mon_failures++;
                $display("FAIL unexpected_beat: got adr %h dat %h expected no beat", ADR_O, DAT_O);
            end else begin
                mchk("beat_adr", ADR_O, exp_q[0][63:32]);
                mchk("beat_dat", DAT_O, exp_q[0][31:0]);
                mchk("beat_we_cyc", {30'd0, WE_O, CYC_O}, 32'd3);
                if (ACK_I) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic push_row(logic [31:0] a, logic [31:0] x, logic [31:0] y, logic [31:0] z, bit accept);
        iWriteEnable = 1'b1;
        iAddress = a;
        iData = {x, y, z};
        if (accept) begin
            exp_q.push_back({a, x});
            exp_q.push_back({a + 32'd1, y});
            exp_q.push_back({a + 32'd2, z});
        end
        tick();
        iWriteEnable = 1'b0;
    endtask

    task automatic do_reset();
        RST_I = 1'b1;
        iWriteEnable = 1'b0;
        ACK_I = 1'b0;
        exp_q.delete();
        tick();
        tick();
        RST_I = 1'b0;
    endtask

    int b0, s0;

    initial begin
        tick();
        tick();
        @(negedge CLK_I);
        chk("rst_bus", {29'd0, STB_O, CYC_O, WE_O}, 32'd0);
        chk("rst_adr", ADR_O, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_flags", {29'd0, oFull, oEmpty, oOverflow}, 32'b010);
        do_reset();

        // single row, zero-wait slave
        ACK_I = 1'b1;
        push_row(32'h100, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1);
        tick();
        @(negedge CLK_I);
        chk("latency_stb", {31'd0, STB_O}, 32'd1);
        tick(); tick(); tick();
        @(negedge CLK_I);
        chk("zw_cyc_fall", {31'd0, CYC_O}, 32'd0);
        chk("zw_empty", {31'd0, oEmpty}, 32'd1);
        chk("zw_drained", exp_q.size(), 32'd0);

        // wait states: ACK every third cycle
        do_reset();
        push_row(32'h100, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1'b1);
        tick();
        s0 = stb_cycles;
        for (int i = 0; i < 9; i++) begin
            ACK_I = (i % 3 == 2);
            tick();
        end
        ACK_I = 1'b0;
        @(negedge CLK_I);
        chk("ws_stb_cycles", stb_cycles - s0, 32'd9);
        chk("ws_cyc_fall", {31'd0, CYC_O}, 32'd0);
        chk("ws_drained", exp_q.size(), 32'd0);

        // fill and overflow
        do_reset();
        push_row(32'h1000, 32'h11, 32'h12, 32'h13, 1'b1);
        push_row(32'h2000, 32'h21, 32'h22, 32'h23, 1'b1);
        push_row(32'h3000, 32'h31, 32'h32, 32'h33, 1'b1);
        @(negedge CLK_I);
        chk("fill_not_full3", {31'd0, oFull}, 32'd0);
        push_row(32'h4000, 32'h41, 32'h42, 32'h43, 1'b1);
        @(negedge CLK_I);
        chk("fill_full4", {31'd0, oFull}, 32'd1);
        chk("fill_no_ovf", {31'd0, oOverflow}, 32'd0);
        push_row(32'h5000, 32'h51, 32'h52, 32'h53, 1'b0);
        @(negedge CLK_I);
        chk("fill_ovf", {30'd0, oOverflow, oFull}, 32'd3);
        b0 = beats;
        ACK_I = 1'b1;
        repeat (14) tick();
        ACK_I = 1'b0;
        @(negedge CLK_I);
        chk("fill_beats", beats - b0, 32'd12);
        chk("fill_drained", exp_q.size(), 32'd0);
        chk("fill_empty_ovf", {30'd0, oEmpty, oOverflow}, 32'd3);

        // back-to-back rows keep CYC_O high
        do_reset();
        ACK_I = 1'b1;
        push_row(32'h200, 32'hA0, 32'hA1, 32'hA2, 1'b1);
        push_row(32'h300, 32'hB0, 32'hB1, 32'hB2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_I);
            chk($sformatf("b2b_cyc%0d", i), {31'd0, CYC_O}, 32'd1);
            tick();
        end
        @(negedge CLK_I);
        chk("b2b_cyc_fall", {31'd0, CYC_O}, 32'd0);
        chk("b2b_drained", exp_q.size(), 32'd0);

        // push while full in the same cycle as the head row's final ACK
        do_reset();
        push_row(32'h600, 32'h60, 32'h61, 32'h62, 1'b1);
        push_row(32'h700, 32'h70, 32'h71, 32'h72, 1'b1);
        push_row(32'h800, 32'h80, 32'h81, 32'h82, 1'b1);
        push_row(32'h900, 32'h90, 32'h91, 32'h92, 1'b1);
        ACK_I = 1'b1;
        tick();
        tick();
        push_row(32'hA00, 32'hE0, 32'hE1, 32'hE2, 1'b0);
        ACK_I = 1'b0;
        @(negedge CLK_I);
        chk("fp_ovf_notfull", {30'd0, oOverflow, oFull}, 32'b10);
        push_row(32'hB00, 32'hF0, 32'hF1, 32'hF2, 1'b1);
        @(negedge CLK_I);
        chk("fp_full_again", {31'd0, oFull}, 32'd1);
        ACK_I = 1'b1;
        repeat (14) tick();
        ACK_I = 1'b0;
        @(negedge CLK_I);
        chk("fp_drained", exp_q.size(), 32'd0);
        chk("fp_empty", {31'd0, oEmpty}, 32'd1);

        // reset during beat 1
        do_reset();
        push_row(32'h400, 32'hD0, 32'hD1, 32'hD2, 1'b1);
        tick();
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        #1;
        RST_I = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_bus", {30'd0, STB_O, CYC_O}, 32'd0);
        chk("rst_mid_empty", {31'd0, oEmpty}, 32'd1);
        b0 = beats;
        tick();
        RST_I = 1'b0;
        ACK_I = 1'b1;
        repeat (6) tick();
        @(negedge CLK_I);
        chk("rst_no_beats", beats - b0, 32'd0);

        // address wrap
        push_row(32'hFFFFFFFF, 32'h01, 32'h02, 32'h03, 1'b1);
        repeat (6) tick();
        ACK_I = 1'b0;
        @(negedge CLK_I);
        chk("wrap_drained", exp_q.size(), 32'd0);
        chk("wrap_empty", {31'd0, oEmpty}, 32'd1);

        checks += mon_checks;
        failures += mon_failures;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/omem_wb_write_buffer.md
Name: omem_wb_write_buffer

Overview:
- Sits directly upstream of the Wishbone bus on the output-memory path.
- Accepts 96-bit result rows (X,Y,Z) with a base address from the execution core and buffers them in a small FIFO.
- Serialises each row into three 32-bit Wishbone classic write cycles with full STB/ACK handshaking.
- Lets a slow or stalled output memory apply backpressure without losing results.

Parameters:
- WB_WIDTH, 32, Wishbone data/address width.
- ROW_WIDTH, 96, width of one data row (3 x WB_WIDTH).
- DEPTH, 4, FIFO entries. Power of two, >= 2.

Ports:
- CLK_I  in  1  clock; all logic rising-edge.
- RST_I  in  1  asynchronous, active-high reset.
- iWriteEnable  in  1  push request, one row per cycle.
- iAddress  in  WB_WIDTH  base word address of the row.
- iData  in  ROW_WIDTH  row data; [95:64]=X, [63:32]=Y, [31:0]=Z.
- oFull  out  1  FIFO holds DEPTH entries.
- oEmpty  out  1  FIFO empty and no bus transfer in progress.
- oOverflow  out  1  sticky: a push was dropped.
- ADR_O  out  WB_WIDTH  Wishbone address.
- DAT_O  out  WB_WIDTH  Wishbone write data.
- WE_O  out  1  Wishbone write enable.
- STB_O  out  1  Wishbone strobe.
- CYC_O  out  1  Wishbone cycle.
- ACK_I  in  1  Wishbone acknowledge.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count = 0; FSM = IDLE; beat counter = 0.
  - STB_O = CYC_O = WE_O = 0; ADR_O = DAT_O = 0.
  - oFull = 0, oEmpty = 1, oOverflow = 0.
  - Reset mid-transfer drops CYC_O/STB_O immediately and discards all buffered rows.
- FIFO:
  - Entry = {address, data}; ROW_WIDTH + WB_WIDTH bits.
  - Write/read pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Push: iWriteEnable && !oFull. Entry is written at the rising edge and is visible to the FSM the next cycle.
  - If iWriteEnable && oFull, the row is dropped and oOverflow is set (cleared only by reset).
  - oFull is decided from the registered count only. A pop in the same cycle does not make room for a push in that cycle.
  - Simultaneous push (not full) and pop: count is unchanged, both pointers advance.
- FSM states: IDLE, XFER.
  - IDLE:
    - If FIFO is non-empty: load beat = 0, go to XFER.
    - Same edge: CYC_O = STB_O = WE_O = 1, ADR_O = head.addr, DAT_O = head.data[95:64].
    - Latency: push in cycle N into an empty, idle block gives STB_O = 1 in cycle N+1.
  - XFER:
    - Outputs hold stable while ACK_I = 0; stalls have no limit.
    - On ACK_I with beat < 2: beat++, ADR_O = head.addr + beat + 1 (mod 2^WB_WIDTH, wraps), DAT_O = next 32-bit slice (Y, then Z). STB_O and CYC_O stay high.
    - On ACK_I with beat == 2: pop head.
      - If FIFO holds another row after this pop, go straight to beat 0 of that row with CYC_O held high (back-to-back rows, no idle cycle).
      - Otherwise STB_O = CYC_O = WE_O = 0 and go to IDLE.
- ACK_I is ignored while STB_O = 0.
- oEmpty = (count == 0) && state == IDLE. It is registered and asserts the cycle after the final ACK when nothing else is queued.
- Exactly one beat completes per ACK; a 3-row burst takes 9 ACKs.

Test Plan:
- Single row, zero-wait slave:
  - Stimulus: push addr=0x100, data=X:0xAAAA0001 Y:0xBBBB0002 Z:0xCCCC0003; ACK_I tied high.
  - Required: STB_O rises the cycle after the push; beats are 0x100/0xAAAA0001, 0x101/0xBBBB0002, 0x102/0xCCCC0003 on three consecutive cycles; CYC_O falls the next cycle; oEmpty = 1.
- Wait states:
  - Stimulus: same row, ACK_I asserted only every 3rd cycle.
  - Required: ADR_O/DAT_O stay stable between ACKs; transfer completes in 9 cycles of STB_O high.
- Fill and overflow:
  - Stimulus: ACK_I held low, push 5 rows (DEPTH=4).
  - Required: oFull = 1 after the 4th push (3 queued plus 1 on the bus does not count; count=4); 5th push is dropped and oOverflow = 1; after ACK_I is released exactly 12 beats appear, in push order.
- Back-to-back rows:
  - Stimulus: push rows at 0x200 and 0x300, zero-wait slave.
  - Required: CYC_O stays high for 6 consecutive beats; ADR sequence is 0x200, 0x201, 0x202, 0x300, 0x301, 0x302.
- Push while full and popping:
  - Stimulus: with count = 4, assert iWriteEnable in the same cycle as the final ACK of the head row.
  - Required: the push is dropped, oOverflow = 1, count = 3.
- Reset mid-transfer and address wrap:
  - Stimulus: assert RST_I during beat 1.
  - Required: CYC_O/STB_O = 0 in the same cycle; oEmpty = 1; no further beats.
  - Stimulus: a subsequent row at addr 0xFFFFFFFF.
  - Required: addresses 0xFFFFFFFF, 0x00000000, 0x00000001.
